// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexes four 4-bit hex digits onto a common-anode 4-digit
//   7-segment display (Basys 3). Owns the refresh timing, tear-free latching
//   of the digit values, hex-to-segment decode and inter-digit ghost blanking.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (>= 4)
//   BLANK_CYCLES  all-anodes-off cycles at the start of each slot (< REFRESH_DIV)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   a_in..d_in  digit values, A leftmost (an[3]) .. D rightmost (an[0])
//   dp_mask     decimal-point request per digit, bit3=A .. bit0=D, active-high
//   disp_en     1 = display on, 0 = all anodes off (scan keeps running)
//   seg         cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp          decimal-point cathode, active-low
//   an          anodes, active-low, an[3]=A .. an[0]=D
//   frame_done  one-cycle pulse on the last cycle of the digit D slot
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zeros of A, B, C are
//                          suppressed (digit D is always shown).
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] c_in,
  input  logic [3:0] d_in,
  input  logic [3:0] dp_mask,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int              CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_CNT = CW'(BLANK_CYCLES);

  localparam logic [1:0] S_A = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_C = 2'd2;
  localparam logic [1:0] S_D = 2'd3;

  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic          first_q;   // set until the first edge after reset release
  logic          tc;
  logic          load;

  logic [3:0]    sh_a, sh_b, sh_c, sh_d;
  logic [3:0]    sh_dp;
  logic [2:0]    sh_blank;  // per-slot blank flags for A, B, C

  assign tc   = (cnt == CNT_MAX);
  // One sample feeds a whole frame: taken on the TC that wraps S_D -> S_A,
  // plus once right after reset so the very first frame has defined data.
  assign load = first_q | (tc & (state == S_D));

  // -------------------------------------------------------------------------
  // Slot counter and scan FSM
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update from the same pre-edge values; blocking here would make
  // results depend on block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      state   <= S_A;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (tc) begin
        cnt <= '0;
        case (state)
          S_A:     state <= S_B;
          S_B:     state <= S_C;
          S_C:     state <= S_D;
          default: state <= S_A;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shadow latch
  // -------------------------------------------------------------------------
  // NOTE: the shadow digits are ordinary flops (not a RAM), so they take the
  // async reset like everything else and the display never shows X data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_c     <= '0;
      sh_d     <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_a  <= a_in;
      sh_b  <= b_in;
      sh_c  <= c_in;
      sh_d  <= d_in;
      sh_dp <= dp_mask;
`ifdef LEADING_ZERO_BLANK_EN
      sh_blank[0] <= (a_in == 4'd0);
      sh_blank[1] <= (a_in == 4'd0) && (b_in == 4'd0);
      sh_blank[2] <= (a_in == 4'd0) && (b_in == 4'd0) && (c_in == 4'd0);
`else
      sh_blank    <= '0;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Hex to active-low gfedcba
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Next-output logic
  // -------------------------------------------------------------------------
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_blank;
  logic [3:0] cur_an;
  logic       drive_on;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cur_digit = sh_d;
    cur_dp    = sh_dp[0];
    cur_blank = 1'b0;
    cur_an    = 4'b1110;
    case (state)
      S_A: begin
        cur_digit = sh_a;
        cur_dp    = sh_dp[3];
        cur_blank = sh_blank[0];
        cur_an    = 4'b0111;
      end
      S_B: begin
        cur_digit = sh_b;
        cur_dp    = sh_dp[2];
        cur_blank = sh_blank[1];
        cur_an    = 4'b1011;
      end
      S_C: begin
        cur_digit = sh_c;
        cur_dp    = sh_dp[1];
        cur_blank = sh_blank[2];
        cur_an    = 4'b1101;
      end
      default: ;
    endcase
  end

  // The guard band at the start of each slot keeps the previous digit's
  // cathode pattern from ghosting onto the next anode.
  assign drive_on = disp_en && !(cnt < BLANK_CNT) && !cur_blank;
  assign an_d     = drive_on ? cur_an                 : 4'b1111;
  assign seg_d    = drive_on ? hex_to_seg(cur_digit)  : 7'h7F;
  assign dp_d     = drive_on ? ~cur_dp                : 1'b1;

  // -------------------------------------------------------------------------
  // Output registers: fixed one-cycle lag behind cnt/state. A single anode
  // code per cycle comes out of one register, so at most one anode is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= tc && (state == S_D);
    end
  end

endmodule
